// File: rtl/bus_mux_reg.sv
// bus_mux_reg: registered CPU bus multiplexer.
// Resolves one source word per cycle from out-enable strobes, pipelines the
// result through one or two register stages, and tracks multi-driver conflicts.
//
// Output qualifier semantics (there is no back-pressure on this bus):
//   bus_valid=1 means bus_out and bus_src_idx carry exactly one resolved source
//   word for this cycle. bus_valid=0 means bus_out is an idle value (held word
//   or zero) and bus_src_idx still shows the last source that was driven.
//   conflict marks the word that had two or more enables asserted. It is
//   aligned with bus_out and can be high together with bus_valid=1 in priority mode.

module bus_mux_reg #(
    parameter  int NUM_SRC       = 24,
    parameter  int DATA_W        = 32,
    parameter  int PIPE_STAGES   = 1,
    parameter  int PRIORITY_MODE = 0,
    parameter  int HOLD_MODE     = 1,
    localparam int SEL_W         = $clog2(NUM_SRC)
) (
    input  logic                      clock,
    input  logic                      clear,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]        src_out_en,
    input  logic                      err_clr,
    output logic [DATA_W-1:0]         bus_out,
    output logic                      bus_valid,
    output logic [SEL_W-1:0]          bus_src_idx,
    output logic                      conflict,
    output logic                      conflict_sticky,
    output logic [7:0]                conflict_count
);

    // ------------------------------------------------------------------
    // Resolution of the current enable vector
    // ------------------------------------------------------------------
    logic               en_any;
    logic               en_multi;
    logic [SEL_W-1:0]   low_idx;
    logic [NUM_SRC-1:0] low_oh;
    logic [DATA_W-1:0]  sel_data;

    logic               res_valid;
    logic [DATA_W-1:0]  res_data;
    logic               res_conf;

    // Scan from index 0 upward: the first set bit is the lowest index, any
    // further set bit marks a multi-driver conflict.
    always_comb begin
        en_any   = 1'b0;
        en_multi = 1'b0;
        low_idx  = '0;
        low_oh   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_out_en[i]) begin
                if (en_any) begin
                    en_multi = 1'b1;
                end else begin
                    low_idx   = SEL_W'(i);
                    low_oh[i] = 1'b1;
                end
                en_any = 1'b1;
            end
        end
    end

    // AND-OR mux on the one-hot lowest enable, so an unselected source
    // (even one carrying X) never reaches the bus.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sel_data = sel_data | (src_data[i*DATA_W +: DATA_W] & {DATA_W{low_oh[i]}});
        end
    end

    // In strict mode a conflict produces no valid word; in priority mode
    // the lowest asserted index still drives the bus.
    assign res_valid = en_any && (!en_multi || (PRIORITY_MODE != 0));
    assign res_conf  = en_multi;
    assign res_data  = res_valid ? sel_data : '0;

    // ------------------------------------------------------------------
    // Optional first pipeline stage; data, valid, idx and conflict travel
    // together so the final stage sees a coherent word.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] fin_data;
    logic              fin_valid;
    logic [SEL_W-1:0]  fin_idx;
    logic              fin_conf;

    generate
        if (PIPE_STAGES == 2) begin : g_two_stage
            logic [DATA_W-1:0] s0_data;
            logic              s0_valid;
            logic [SEL_W-1:0]  s0_idx;
            logic              s0_conf;

            // Stage 0 register: capture the resolved word unconditionally.
            always_ff @(posedge clock or negedge clear) begin
                if (!clear) begin
                    s0_data  <= '0;
                    s0_valid <= 1'b0;
                    s0_idx   <= '0;
                    s0_conf  <= 1'b0;
                end else begin
                    s0_data  <= res_data;
                    s0_valid <= res_valid;
                    s0_idx   <= low_idx;
                    s0_conf  <= res_conf;
                end
            end

            assign fin_data  = s0_data;
            assign fin_valid = s0_valid;
            assign fin_idx   = s0_idx;
            assign fin_conf  = s0_conf;
        end else begin : g_one_stage
            assign fin_data  = res_data;
            assign fin_valid = res_valid;
            assign fin_idx   = low_idx;
            assign fin_conf  = res_conf;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Final (output) stage and hold register
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] idle_word;

    // Idle value when nothing drives the bus: last valid word or zero.
    assign idle_word = (HOLD_MODE != 0) ? hold_q : '0;

    // Output register: a valid word updates data, idx and the hold register;
    // a strict-mode conflict forces zero; an idle cycle shows idle_word.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            bus_out     <= '0;
            bus_valid   <= 1'b0;
            bus_src_idx <= '0;
            conflict    <= 1'b0;
            hold_q      <= '0;
        end else begin
            bus_valid <= fin_valid;
            conflict  <= fin_conf;
            if (fin_valid) begin
                bus_out     <= fin_data;
                bus_src_idx <= fin_idx;
                hold_q      <= fin_data;
            end else if (fin_conf) begin
                bus_out <= '0;
            end else begin
                bus_out <= idle_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Conflict bookkeeping, updated at the edge the conflict pulse is
    // registered. A conflict coinciding with err_clr restarts the count at 1.
    // ------------------------------------------------------------------
    // Sticky flag and saturating counter.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            conflict_sticky <= 1'b0;
            conflict_count  <= 8'd0;
        end else if (err_clr && fin_conf) begin
            conflict_sticky <= 1'b1;
            conflict_count  <= 8'd1;
        end else if (err_clr) begin
            conflict_sticky <= 1'b0;
            conflict_count  <= 8'd0;
        end else if (fin_conf) begin
            conflict_sticky <= 1'b1;
            if (conflict_count != 8'hFF) begin
                conflict_count <= conflict_count + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Simulation checks
    // ------------------------------------------------------------------
    // Enables must be fully known whenever the block is out of reset.
    a_en_known: assert property (@(posedge clock) disable iff (!clear)
        !$isunknown(src_out_en));

    // The conflict counter saturates rather than wrapping.
    a_count_saturates: assert property (@(posedge clock) disable iff (!clear)
        (conflict_count == 8'hFF && !err_clr) |=> (conflict_count == 8'hFF));

    // A registered conflict always leaves the sticky flag set.
    a_sticky_follows: assert property (@(posedge clock) disable iff (!clear)
        conflict |-> conflict_sticky);

endmodule

// File: tb/tb_bus_mux_reg.sv
// Directed testbench for bus_mux_reg. Three instances share one stimulus:
//   a: PIPE_STAGES=1, strict,   HOLD_MODE=0
//   b: PIPE_STAGES=2, priority, HOLD_MODE=1
//   c: PIPE_STAGES=1, strict,   HOLD_MODE=1
module tb_bus_mux_reg;

    localparam int NS = 24;
    localparam int DW = 32;
    localparam int SW = $clog2(NS);

    logic              clock;
    logic              clear;
    logic [NS*DW-1:0]  src_data;
    logic [NS-1:0]     src_out_en;
    logic              err_clr;

    logic [DW-1:0] a_bus_out, b_bus_out, c_bus_out;
    logic          a_bus_valid, b_bus_valid, c_bus_valid;
    logic [SW-1:0] a_bus_src_idx, b_bus_src_idx, c_bus_src_idx;
    logic          a_conflict, b_conflict, c_conflict;
    logic          a_sticky, b_sticky, c_sticky;
    logic [7:0]    a_count, b_count, c_count;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [NS-1:0] CONF_EN = (NS'(1) << 2) | (NS'(1) << 9);

    bus_mux_reg #(.NUM_SRC(NS), .DATA_W(DW), .PIPE_STAGES(1), .PRIORITY_MODE(0), .HOLD_MODE(0)) u_a (
        .clock(clock), .clear(clear), .src_data(src_data), .src_out_en(src_out_en), .err_clr(err_clr),
        .bus_out(a_bus_out), .bus_valid(a_bus_valid), .bus_src_idx(a_bus_src_idx),
        .conflict(a_conflict), .conflict_sticky(a_sticky), .conflict_count(a_count)
    );

    bus_mux_reg #(.NUM_SRC(NS), .DATA_W(DW), .PIPE_STAGES(2), .PRIORITY_MODE(1), .HOLD_MODE(1)) u_b (
        .clock(clock), .clear(clear), .src_data(src_data), .src_out_en(src_out_en), .err_clr(err_clr),
        .bus_out(b_bus_out), .bus_valid(b_bus_valid), .bus_src_idx(b_bus_src_idx),
        .conflict(b_conflict), .conflict_sticky(b_sticky), .conflict_count(b_count)
    );

    bus_mux_reg #(.NUM_SRC(NS), .DATA_W(DW), .PIPE_STAGES(1), .PRIORITY_MODE(0), .HOLD_MODE(1)) u_c (
        .clock(clock), .clear(clear), .src_data(src_data), .src_out_en(src_out_en), .err_clr(err_clr),
        .bus_out(c_bus_out), .bus_valid(c_bus_valid), .bus_src_idx(c_bus_src_idx),
        .conflict(c_conflict), .conflict_sticky(c_sticky), .conflict_count(c_count)
    );

    // Clock generation.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: counts and reports.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_bus(input string tag,
                             input logic [DW-1:0] data, input logic valid,
                             input logic [SW-1:0] idx, input logic conf,
                             input logic [DW-1:0] e_data, input logic e_valid,
                             input logic [SW-1:0] e_idx, input logic e_conf);
        check({tag, ".data"},  data,        e_data);
        check({tag, ".valid"}, 32'(valid),  32'(e_valid));
        check({tag, ".idx"},   32'(idx),    32'(e_idx));
        check({tag, ".conf"},  32'(conf),   32'(e_conf));
    endtask

    task automatic check_err(input string tag, input logic sticky, input logic [7:0] count,
                             input logic e_sticky, input logic [7:0] e_count);
        check({tag, ".sticky"}, 32'(sticky), 32'(e_sticky));
        check({tag, ".count"},  32'(count),  32'(e_count));
    endtask

    // Driver tasks.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_src(input int idx, input logic [DW-1:0] val);
        src_data[idx*DW +: DW] = val;
    endtask

    task automatic drive_one(input int idx);
        src_out_en = NS'(1) << idx;
    endtask

    initial begin
        clear      = 1'b0;
        src_data   = '0;
        src_out_en = '0;
        err_clr    = 1'b0;
        steps(2);

        // Reset state.
        check_bus("rst_a", a_bus_out, a_bus_valid, a_bus_src_idx, a_conflict, 32'h0, 1'b0, 5'd0, 1'b0);
        check_bus("rst_b", b_bus_out, b_bus_valid, b_bus_src_idx, b_conflict, 32'h0, 1'b0, 5'd0, 1'b0);
        check_err("rst_c", c_sticky, c_count, 1'b0, 8'd0);
        clear = 1'b1;

        // Single source, one-edge latency on the single-stage instance.
        set_src(5, 32'hDEADBEEF);
        set_src(3, 32'h33333333);
        set_src(7, 32'h77777777);
        set_src(20, 32'h20202020);
        drive_one(5);
        step();
        check_bus("t1_a", a_bus_out, a_bus_valid, a_bus_src_idx, a_conflict, 32'hDEADBEEF, 1'b1, 5'd5, 1'b0);
        check("t1_b_not_yet.valid", 32'(b_bus_valid), 32'd0);

        // Back-to-back words through the two-stage instance.
        drive_one(3);
        step();
        check_bus("t2_b5", b_bus_out, b_bus_valid, b_bus_src_idx, b_conflict, 32'hDEADBEEF, 1'b1, 5'd5, 1'b0);
        check_bus("t2_a3", a_bus_out, a_bus_valid, a_bus_src_idx, a_conflict, 32'h33333333, 1'b1, 5'd3, 1'b0);
        drive_one(7);
        step();
        check_bus("t2_b3", b_bus_out, b_bus_valid, b_bus_src_idx, b_conflict, 32'h33333333, 1'b1, 5'd3, 1'b0);
        drive_one(20);
        step();
        check_bus("t2_b7", b_bus_out, b_bus_valid, b_bus_src_idx, b_conflict, 32'h77777777, 1'b1, 5'd7, 1'b0);
        src_out_en = '0;
        step();
        check_bus("t2_b20", b_bus_out, b_bus_valid, b_bus_src_idx, b_conflict, 32'h20202020, 1'b1, 5'd20, 1'b0);
        check_bus("t2_a_idle", a_bus_out, a_bus_valid, a_bus_src_idx, a_conflict, 32'h0, 1'b0, 5'd20, 1'b0);
        check_bus("t2_c_idle", c_bus_out, c_bus_valid, c_bus_src_idx, c_conflict, 32'h20202020, 1'b0, 5'd20, 1'b0);
        step();
        check_bus("t2_b_idle", b_bus_out, b_bus_valid, b_bus_src_idx, b_conflict, 32'h20202020, 1'b0, 5'd20, 1'b0);

        // Hold behaviour: one word then three idle cycles.
        set_src(1, 32'h12345678);
        drive_one(1);
        step();
        src_out_en = '0;
        steps(3);
        check_bus("t3_a_hold0", a_bus_out, a_bus_valid, a_bus_src_idx, a_conflict, 32'h0, 1'b0, 5'd1, 1'b0);
        check_bus("t3_b_hold1", b_bus_out, b_bus_valid, b_bus_src_idx, b_conflict, 32'h12345678, 1'b0, 5'd1, 1'b0);
        check_bus("t3_c_hold1", c_bus_out, c_bus_valid, c_bus_src_idx, c_conflict, 32'h12345678, 1'b0, 5'd1, 1'b0);

        // Two-driver conflict in both resolution modes.
        set_src(2, 32'hAAAA0000);
        set_src(9, 32'h00005555);
        src_out_en = CONF_EN;
        step();
        src_out_en = '0;
        check_bus("t4_a", a_bus_out, a_bus_valid, a_bus_src_idx, a_conflict, 32'h0, 1'b0, 5'd1, 1'b1);
        check_bus("t4_c", c_bus_out, c_bus_valid, c_bus_src_idx, c_conflict, 32'h0, 1'b0, 5'd1, 1'b1);
        check_err("t4_a", a_sticky, a_count, 1'b1, 8'd1);
        check_err("t4_b_pre", b_sticky, b_count, 1'b0, 8'd0);
        step();
        check_bus("t4_b", b_bus_out, b_bus_valid, b_bus_src_idx, b_conflict, 32'hAAAA0000, 1'b1, 5'd2, 1'b1);
        check_err("t4_b", b_sticky, b_count, 1'b1, 8'd1);
        check_bus("t4_c_after", c_bus_out, c_bus_valid, c_bus_src_idx, c_conflict, 32'h12345678, 1'b0, 5'd1, 1'b0);
        check_err("t4_a_after", a_sticky, a_count, 1'b1, 8'd1);
        step();
        check_bus("t4_b_idle", b_bus_out, b_bus_valid, b_bus_src_idx, b_conflict, 32'hAAAA0000, 1'b0, 5'd2, 1'b0);

        // Saturation: a/c reach 255 exactly after 254 more conflicts, b lags by one.
        src_out_en = CONF_EN;
        steps(254);
        check_err("t5_a_255", a_sticky, a_count, 1'b1, 8'd255);
        check_err("t5_c_255", c_sticky, c_count, 1'b1, 8'd255);
        check_err("t5_b_254", b_sticky, b_count, 1'b1, 8'd254);
        steps(46);
        src_out_en = '0;
        steps(2);
        check_err("t5_a_sat", a_sticky, a_count, 1'b1, 8'd255);
        check_err("t5_b_sat", b_sticky, b_count, 1'b1, 8'd255);

        // err_clr alone.
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_err("t5_a_clr", a_sticky, a_count, 1'b0, 8'd0);
        check_err("t5_b_clr", b_sticky, b_count, 1'b0, 8'd0);
        check_err("t5_c_clr", c_sticky, c_count, 1'b0, 8'd0);

        // err_clr coincident with a conflict at the output edge.
        src_out_en = CONF_EN;
        err_clr    = 1'b1;
        step();
        check_err("t5_a_coinc", a_sticky, a_count, 1'b1, 8'd1);
        check_err("t5_b_noconf", b_sticky, b_count, 1'b0, 8'd0);
        step();
        check_err("t5_a_coinc2", a_sticky, a_count, 1'b1, 8'd1);
        check_err("t5_b_coinc", b_sticky, b_count, 1'b1, 8'd1);
        err_clr    = 1'b0;
        src_out_en = '0;
        step();
        check_err("t5_a_after", a_sticky, a_count, 1'b1, 8'd1);
        check_err("t5_b_after", b_sticky, b_count, 1'b1, 8'd2);

        // Reset with words in flight through the two-stage instance.
        drive_one(3);
        step();
        drive_one(7);
        step();
        check_bus("t6_b_pre", b_bus_out, b_bus_valid, b_bus_src_idx, b_conflict, 32'h33333333, 1'b1, 5'd3, 1'b0);
        #2;
        clear      = 1'b0;
        src_out_en = '0;
        #1;
        check_bus("t6_a_async", a_bus_out, a_bus_valid, a_bus_src_idx, a_conflict, 32'h0, 1'b0, 5'd0, 1'b0);
        check_bus("t6_b_async", b_bus_out, b_bus_valid, b_bus_src_idx, b_conflict, 32'h0, 1'b0, 5'd0, 1'b0);
        check_err("t6_a_async", a_sticky, a_count, 1'b0, 8'd0);
        check_err("t6_b_async", b_sticky, b_count, 1'b0, 8'd0);
        step();
        clear = 1'b1;
        steps(3);
        check_bus("t6_b_after", b_bus_out, b_bus_valid, b_bus_src_idx, b_conflict, 32'h0, 1'b0, 5'd0, 1'b0);
        check_bus("t6_c_after", c_bus_out, c_bus_valid, c_bus_src_idx, c_conflict, 32'h0, 1'b0, 5'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
